// File: rtl/warp_register_file_if.sv
// Control, operand and writeback bundle between the scheduler/decoder and one
// thread lane's warp register file.
interface warp_register_file_if #(
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  parameter int NUM_WARPS         = 2,
  parameter int THREADS_PER_BLOCK = 4
);
  localparam int WW  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int AW  = $clog2(NUM_REGS);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                 enable;
  logic [3:0]           core_state;
  logic [WW-1:0]        warp_id;
  logic                 blk_load;
  logic [WW-1:0]        blk_warp;
  logic [DATA_BITS-1:0] block_id;
  logic [TCW-1:0]       thread_count;
  logic [AW-1:0]        rd_addr;
  logic [AW-1:0]        rs_addr;
  logic [AW-1:0]        rt_addr;
  logic                 reg_write_enable;
  logic                 nzp_write_enable;
  logic [2:0]           decoded_nzp;
  logic [1:0]           reg_input_mux;
  logic [DATA_BITS-1:0] immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic                 load_issue;
  logic                 lsu_wb_valid;
  logic [WW-1:0]        lsu_wb_warp;
  logic [AW-1:0]        lsu_wb_rd;
  logic [DATA_BITS-1:0] lsu_wb_data;
  logic [DATA_BITS-1:0] rs;
  logic [DATA_BITS-1:0] rt;
  logic [2:0]           nzp;
  logic                 hazard;

  modport master (
    output enable, core_state, warp_id, blk_load, blk_warp, block_id, thread_count,
           rd_addr, rs_addr, rt_addr, reg_write_enable, nzp_write_enable, decoded_nzp,
           reg_input_mux, immediate, alu_out, load_issue,
           lsu_wb_valid, lsu_wb_warp, lsu_wb_rd, lsu_wb_data,
    input  rs, rt, nzp, hazard
  );

  modport slave (
    input  enable, core_state, warp_id, blk_load, blk_warp, block_id, thread_count,
           rd_addr, rs_addr, rt_addr, reg_write_enable, nzp_write_enable, decoded_nzp,
           reg_input_mux, immediate, alu_out, load_issue,
           lsu_wb_valid, lsu_wb_warp, lsu_wb_rd, lsu_wb_data,
    output rs, rt, nzp, hazard
  );
endinterface

// File: rtl/warp_register_file.sv
// Per-lane register file with one bank, NZP flags and pending-load scoreboard
// per warp; the top three addresses are the read-only block/thread context.
module warp_register_file #(
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  parameter int NUM_WARPS         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input logic                  clk,
  input logic                  reset,
  warp_register_file_if.slave  bus
);
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int AW = $clog2(NUM_REGS);

  localparam logic [3:0]    ISSUE  = 4'b0011;
  localparam logic [3:0]    UPDATE = 4'b0111;
  localparam logic [1:0]    MUX_ARITH = 2'b00;
  localparam logic [1:0]    MUX_CONST = 2'b10;
  localparam logic [1:0]    MUX_MOVC  = 2'b11;
  localparam logic [AW-1:0] RO_B = AW'(NUM_REGS - 3);
  localparam logic [AW-1:0] RO_D = AW'(NUM_REGS - 2);
  localparam logic [AW-1:0] RO_T = AW'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][DATA_BITS-1:0] bank [NUM_WARPS];
  logic [NUM_REGS-1:0]                pending [NUM_WARPS];
  logic [2:0]                         nzp_all [NUM_WARPS];
  logic [DATA_BITS-1:0]               blk_all [NUM_WARPS];
  logic [DATA_BITS-1:0]               dim_all [NUM_WARPS];

  logic [DATA_BITS-1:0] rs_reg, rt_reg;
  logic [DATA_BITS-1:0] rs_next, rt_next;
  logic [DATA_BITS-1:0] upd_value;
  logic                 is_issue, is_update;
  logic                 rd_writable, lsu_writable;
  logic                 movc_take, upd_write, pend_set;

  assign is_issue     = bus.enable && (bus.core_state == ISSUE);
  assign is_update    = bus.enable && (bus.core_state == UPDATE);
  assign rd_writable  = bus.rd_addr < RO_B;
  assign lsu_writable = bus.lsu_wb_rd < RO_B;
  // MOVC tests the flags held before this cycle against the decoded condition.
  assign movc_take    = |(nzp_all[bus.warp_id] & bus.decoded_nzp);
  assign pend_set     = is_issue && bus.load_issue && rd_writable;

  always_comb begin
    upd_value = bus.alu_out;
    upd_write = 1'b0;
    if (is_update && bus.reg_write_enable && rd_writable) begin
      case (bus.reg_input_mux)
        MUX_ARITH: begin upd_value = bus.alu_out;   upd_write = 1'b1;      end
        MUX_CONST: begin upd_value = bus.immediate; upd_write = 1'b1;      end
        MUX_MOVC:  begin upd_value = rs_reg;        upd_write = movc_take; end
        default:   begin upd_value = bus.alu_out;   upd_write = 1'b0;      end
      endcase
    end
  end

  function automatic logic [DATA_BITS-1:0] read_reg(input logic [WW-1:0] w,
                                                    input logic [AW-1:0] a);
    if (a == RO_T)      return DATA_BITS'(THREAD_ID);
    else if (a == RO_D) return dim_all[w];
    else if (a == RO_B) return blk_all[w];
    else                return bank[w][a];
  endfunction

  always_comb begin
    rs_next = read_reg(bus.warp_id, bus.rs_addr);
    rt_next = read_reg(bus.warp_id, bus.rt_addr);
  end

  generate
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic [NUM_REGS-1:0][DATA_BITS-1:0] regs_reg;
      logic [NUM_REGS-1:0]                pend_reg;
      logic [2:0]                         nzp_reg;
      logic [DATA_BITS-1:0]               blk_reg, dim_reg;
      logic                               warp_sel, lsu_sel, blk_sel;

      assign warp_sel = (bus.warp_id == WW'(gi));
      assign lsu_sel  = bus.lsu_wb_valid && lsu_writable && (bus.lsu_wb_warp == WW'(gi));
      assign blk_sel  = bus.blk_load && (bus.blk_warp == WW'(gi));

      // LSU data beats a same-cycle UPDATE write; a pending set beats the LSU clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_reg <= '0;
          pend_reg <= '0;
          nzp_reg  <= '0;
          blk_reg  <= '0;
          dim_reg  <= '0;
        end else if (bus.enable) begin
          if (upd_write && warp_sel)
            regs_reg[bus.rd_addr] <= upd_value;
          if (lsu_sel) begin
            regs_reg[bus.lsu_wb_rd] <= bus.lsu_wb_data;
            pend_reg[bus.lsu_wb_rd] <= 1'b0;
          end
          if (pend_set && warp_sel)
            pend_reg[bus.rd_addr] <= 1'b1;
          if (is_update && bus.nzp_write_enable && warp_sel)
            nzp_reg <= bus.alu_out[2:0];
          if (blk_sel) begin
            blk_reg <= bus.block_id;
            dim_reg <= DATA_BITS'(bus.thread_count);
          end
        end
      end

      assign bank[gi]    = regs_reg;
      assign pending[gi] = pend_reg;
      assign nzp_all[gi] = nzp_reg;
      assign blk_all[gi] = blk_reg;
      assign dim_all[gi] = dim_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_reg <= '0;
      rt_reg <= '0;
    end else if (is_issue) begin
      rs_reg <= rs_next;
      rt_reg <= rt_next;
    end
  end

  assign bus.rs     = rs_reg;
  assign bus.rt     = rt_reg;
  assign bus.nzp    = nzp_all[bus.warp_id];
  assign bus.hazard = bus.enable & (pending[bus.warp_id][bus.rs_addr] |
                                    pending[bus.warp_id][bus.rt_addr] |
                                    pending[bus.warp_id][bus.rd_addr]);
endmodule

// File: tb/tb_warp_register_file.sv
// Directed and randomized bench for warp_register_file against a flat
// array model of every warp's register view, flags and pending loads.
`timescale 1ns/100ps
module tb_warp_register_file;
  localparam int DB = 8, NR = 16, NW = 2, TPB = 4, TID = 3;
  localparam int RO_B = NR - 3, RO_D = NR - 2, RO_T = NR - 1;
  localparam logic [3:0] ISSUE = 4'b0011, UPDATE = 4'b0111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  warp_register_file_if #(.DATA_BITS(DB), .NUM_REGS(NR), .NUM_WARPS(NW),
                          .THREADS_PER_BLOCK(TPB)) bus ();
  warp_register_file #(.THREAD_ID(TID), .DATA_BITS(DB), .NUM_REGS(NR),
                       .NUM_WARPS(NW), .THREADS_PER_BLOCK(TPB))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // Model: every warp sees a 16-entry register view including the RO context.
  logic [DB-1:0] m_reg  [NW][NR];
  logic          m_pend [NW][NR];
  logic [2:0]    m_nzp  [NW];
  logic [DB-1:0] m_rs, m_rt;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic bit model_hazard();
    int w = int'(bus.warp_id);
    return bus.enable && (m_pend[w][bus.rs_addr] || m_pend[w][bus.rt_addr] ||
                          m_pend[w][bus.rd_addr]);
  endfunction

  task automatic model_update();
    int w, lw, bw, rd;
    logic [DB-1:0] old_rs, n_rs, n_rt;
    logic [2:0] old_nzp;
    if (reset) begin
      for (int i = 0; i < NW; i++) begin
        for (int r = 0; r < NR; r++) begin
          m_reg[i][r]  = '0;
          m_pend[i][r] = 1'b0;
        end
        m_reg[i][RO_T] = DB'(TID);
        m_nzp[i] = '0;
      end
      m_rs = '0;
      m_rt = '0;
    end else if (bus.enable) begin
      w  = int'(bus.warp_id);
      lw = int'(bus.lsu_wb_warp);
      bw = int'(bus.blk_warp);
      rd = int'(bus.rd_addr);
      old_rs  = m_rs;
      old_nzp = m_nzp[w];
      n_rs = m_rs;
      n_rt = m_rt;
      if (bus.core_state == ISSUE) begin
        n_rs = m_reg[w][bus.rs_addr];
        n_rt = m_reg[w][bus.rt_addr];
      end
      if (bus.core_state == UPDATE) begin
        if (bus.reg_write_enable && rd < RO_B) begin
          case (bus.reg_input_mux)
            2'b00: m_reg[w][rd] = bus.alu_out;
            2'b10: m_reg[w][rd] = bus.immediate;
            2'b11: if ((old_nzp & bus.decoded_nzp) != 3'b000) m_reg[w][rd] = old_rs;
            default: ;
          endcase
        end
        if (bus.nzp_write_enable) m_nzp[w] = bus.alu_out[2:0];
      end
      if (bus.lsu_wb_valid && int'(bus.lsu_wb_rd) < RO_B) begin
        m_reg[lw][bus.lsu_wb_rd]  = bus.lsu_wb_data;
        m_pend[lw][bus.lsu_wb_rd] = 1'b0;
      end
      if (bus.core_state == ISSUE && bus.load_issue && rd < RO_B) m_pend[w][rd] = 1'b1;
      if (bus.blk_load) begin
        m_reg[bw][RO_B] = bus.block_id;
        m_reg[bw][RO_D] = DB'(bus.thread_count);
      end
      m_rs = n_rs;
      m_rt = n_rt;
    end
  endtask

  // Registered and combinational outputs are compared mid-cycle against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rs", bus.rs, m_rs);
      chk("rt", bus.rt, m_rt);
      chk("nzp", bus.nzp, m_nzp[bus.warp_id]);
      chk("hazard", bus.hazard, model_hazard());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    cycle++;
    #1;
    $display("txn %0d: rst=%0b en=%0b st=%h w=%0d rs_a=%0d rt_a=%0d -> rs=%h rt=%h nzp=%b hz=%0b",
             cycle, reset, bus.enable, bus.core_state, bus.warp_id, bus.rs_addr, bus.rt_addr,
             bus.rs, bus.rt, bus.nzp, bus.hazard);
  endtask

  task automatic idle();
    bus.enable = 1'b1;        bus.core_state = 4'b0000;  bus.warp_id = '0;
    bus.blk_load = 1'b0;      bus.blk_warp = '0;         bus.block_id = '0;
    bus.thread_count = '0;    bus.rd_addr = '0;          bus.rs_addr = '0;
    bus.rt_addr = '0;         bus.reg_write_enable = 1'b0;
    bus.nzp_write_enable = 1'b0; bus.decoded_nzp = '0;   bus.reg_input_mux = '0;
    bus.immediate = '0;       bus.alu_out = '0;          bus.load_issue = 1'b0;
    bus.lsu_wb_valid = 1'b0;  bus.lsu_wb_warp = '0;      bus.lsu_wb_rd = '0;
    bus.lsu_wb_data = '0;
  endtask

  task automatic issue(input int w, input int rsa, input int rta);
    idle();
    bus.core_state = ISSUE;
    bus.warp_id = 1'(w);
    bus.rs_addr = 4'(rsa);
    bus.rt_addr = 4'(rta);
    tick();
  endtask

  task automatic update(input int w, input int rd, input logic [1:0] mux,
                        input logic [7:0] imm, input logic [7:0] alu, input logic [2:0] mask);
    idle();
    bus.core_state = UPDATE;
    bus.warp_id = 1'(w);
    bus.rd_addr = 4'(rd);
    bus.reg_write_enable = 1'b1;
    bus.reg_input_mux = mux;
    bus.immediate = imm;
    bus.alu_out = alu;
    bus.decoded_nzp = mask;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cmp_on = 1'b1;
    chk("reset_rs", bus.rs, 8'h00);
    chk("reset_rt", bus.rt, 8'h00);
    chk("reset_nzp", bus.nzp, 3'b000);
    chk("reset_hazard", bus.hazard, 1'b0);

    issue(0, 15, 0);
    chk("thread_idx", bus.rs, 8'h03);
    chk("r0_zero", bus.rt, 8'h00);

    idle();
    bus.blk_load = 1'b1; bus.blk_warp = 1'b1; bus.block_id = 8'h07; bus.thread_count = 3'd4;
    tick();
    issue(1, 13, 14);
    chk("blk_idx_w1", bus.rs, 8'h07);
    chk("blk_dim_w1", bus.rt, 8'h04);
    issue(0, 13, 14);
    chk("blk_idx_w0", bus.rs, 8'h00);
    chk("blk_dim_w0", bus.rt, 8'h00);

    update(0, 2, 2'b10, 8'h5A, 8'h00, 3'b000);
    update(1, 2, 2'b10, 8'h11, 8'h00, 3'b000);
    update(0, 15, 2'b10, 8'h77, 8'h00, 3'b000);
    issue(0, 2, 15);
    chk("w0_r2", bus.rs, 8'h5A);
    chk("ro_t_kept", bus.rt, 8'h03);
    issue(1, 2, 0);
    chk("w1_r2", bus.rs, 8'h11);

    idle();
    bus.core_state = ISSUE; bus.load_issue = 1'b1; bus.rd_addr = 4'd4;
    tick();
    idle();
    bus.rs_addr = 4'd4;
    #1 chk("hazard_w0", bus.hazard, 1'b1);
    bus.warp_id = 1'b1;
    #1 chk("hazard_w1", bus.hazard, 1'b0);
    idle();
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 4'd4; bus.lsu_wb_data = 8'h33;
    tick();
    idle();
    bus.rs_addr = 4'd4;
    #1 chk("hazard_cleared", bus.hazard, 1'b0);
    issue(0, 4, 0);
    chk("lsu_r4", bus.rs, 8'h33);

    idle();
    bus.core_state = UPDATE; bus.nzp_write_enable = 1'b1; bus.alu_out = 8'h02;
    tick();
    idle();
    #1 chk("cmp_nzp", bus.nzp, 3'b010);
    update(0, 7, 2'b10, 8'h21, 8'h00, 3'b000);
    issue(0, 7, 0);
    update(0, 5, 2'b11, 8'h00, 8'h00, 3'b010);
    issue(0, 5, 0);
    chk("movc_taken", bus.rs, 8'h21);
    issue(0, 2, 0);
    update(0, 5, 2'b11, 8'h00, 8'h00, 3'b100);
    issue(0, 5, 0);
    chk("movc_skipped", bus.rs, 8'h21);

    idle();
    bus.core_state = UPDATE; bus.rd_addr = 4'd6; bus.reg_write_enable = 1'b1;
    bus.reg_input_mux = 2'b00; bus.alu_out = 8'h10;
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 4'd6; bus.lsu_wb_data = 8'h99;
    tick();
    issue(0, 6, 0);
    chk("lsu_beats_update", bus.rs, 8'h99);

    idle();
    bus.core_state = ISSUE; bus.load_issue = 1'b1; bus.rd_addr = 4'd8;
    tick();
    idle();
    bus.rs_addr = 4'd8;
    #1 chk("hazard_r8", bus.hazard, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        idle();
        bus.warp_id = 1'(w);
        bus.rs_addr = 4'(r); bus.rt_addr = 4'(r); bus.rd_addr = 4'(r);
        #1 chk("pending_cleared", bus.hazard, 1'b0);
        tick();
      end
    end
    idle();
    bus.lsu_wb_valid = 1'b1; bus.lsu_wb_rd = 4'd8; bus.lsu_wb_data = 8'h44;
    tick();
    issue(0, 8, 15);
    chk("late_lsu_r8", bus.rs, 8'h44);
    chk("reset_ro_t", bus.rt, 8'h03);

    for (int n = 0; n < 1500; n++) begin
      int sel;
      idle();
      reset = ($urandom_range(0, 63) == 0);
      bus.enable = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: bus.core_state = ISSUE;
        1: bus.core_state = UPDATE;
        2: bus.core_state = 4'b0000;
        default: bus.core_state = 4'($urandom_range(0, 15));
      endcase
      bus.warp_id          = 1'($urandom_range(0, NW - 1));
      bus.rd_addr          = 4'($urandom_range(0, NR - 1));
      bus.rs_addr          = 4'($urandom_range(0, NR - 1));
      bus.rt_addr          = 4'($urandom_range(0, NR - 1));
      bus.reg_write_enable = ($urandom_range(0, 1) == 1);
      bus.nzp_write_enable = ($urandom_range(0, 3) == 0);
      bus.decoded_nzp      = 3'($urandom_range(0, 7));
      bus.reg_input_mux    = 2'($urandom_range(0, 3));
      bus.immediate        = 8'($urandom_range(0, 255));
      bus.alu_out          = 8'($urandom_range(0, 255));
      bus.load_issue       = ($urandom_range(0, 2) == 0);
      bus.blk_load         = ($urandom_range(0, 7) == 0);
      bus.blk_warp         = 1'($urandom_range(0, NW - 1));
      bus.block_id         = 8'($urandom_range(0, 255));
      bus.thread_count     = 3'($urandom_range(0, 7));
      bus.lsu_wb_valid     = ($urandom_range(0, 2) == 0);
      bus.lsu_wb_warp      = 1'($urandom_range(0, NW - 1));
      bus.lsu_wb_rd        = 4'($urandom_range(0, NR - 1));
      bus.lsu_wb_data      = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b0;
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/warp_register_file.md
Name: warp_register_file

Overview:
- Per-thread register file serving NUM_WARPS warp contexts. Each warp has its own bank of NUM_REGS registers, with the top three read-only (%blockIdx, %blockDim, %threadIdx), plus its own NZP flags.
- Adds a pending-load scoreboard. Out-of-order LSU writebacks land asynchronously to the core state machine, and a hazard output lets the scheduler stall dependent instructions.
- One instance per thread lane inside each core, between decoder/scheduler and ALU/LSU.

Parameters:
- THREAD_ID, 0, value of the %threadIdx register.
- DATA_BITS, 8, register/data width.
- NUM_REGS, 16, registers per warp; power of two, >= 8.
- NUM_WARPS, 2, warp contexts; power of two, >= 1.
- THREADS_PER_BLOCK, 4, sizes thread_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  lane active; when low, all state is frozen and LSU writebacks are dropped.
- core_state  in  4  ISSUE=4'b0011, UPDATE=4'b0111.
- warp_id  in  WW=max(1,clog2(NUM_WARPS))  warp being issued/updated.
- blk_load  in  1  loads block context for blk_warp.
- blk_warp  in  WW  target warp of blk_load.
- block_id  in  DATA_BITS  %blockIdx value.
- thread_count  in  clog2(THREADS_PER_BLOCK)+1  %blockDim value, zero-extended.
- rd_addr, rs_addr, rt_addr  in  AW=clog2(NUM_REGS)  decoded addresses.
- reg_write_enable  in  1  decoded rd write.
- nzp_write_enable  in  1  decoded CMP.
- decoded_nzp  in  3  MOVC condition mask.
- reg_input_mux  in  2  00 ARITH, 01 MEMORY, 10 CONST, 11 MOVC.
- immediate, alu_out  in  DATA_BITS  writeback sources.
- load_issue  in  1  LDR issued this ISSUE cycle; marks rd pending.
- lsu_wb_valid  in  1  load data return.
- lsu_wb_warp  in  WW  warp of the return.
- lsu_wb_rd  in  AW  register of the return.
- lsu_wb_data  in  DATA_BITS  return data.
- rs, rt  out  DATA_BITS  latched operands.
- nzp  out  3  NZP of warp_id (combinational select).
- hazard  out  1  combinational; the current instruction depends on a pending load.

Behaviour:
- Writable registers are 0..NUM_REGS-4. RO_B=NUM_REGS-3 is %blockIdx, RO_D=NUM_REGS-2 is %blockDim, RO_T=NUM_REGS-1 is %threadIdx.
- Writes to read-only addresses are silently ignored on every path (UPDATE, LSU, pending set).
- Reset (any cycle, including mid-load):
  - All writable registers, all NZP flags, all pending bits, rs and rt go to 0.
  - RO_B=0 and RO_D=0 for every warp; RO_T=THREAD_ID.
  - hazard=0 the cycle after reset.
  - Any in-flight LSU return arriving after reset is written normally; no pending bit is required for that.
- blk_load (enable high): writes RO_B<=block_id and RO_D<=thread_count of blk_warp. It is independent of core_state; registers are not rewritten every cycle.
- ISSUE (enable high):
  - rs<=bank[warp_id][rs_addr] and rt<=bank[warp_id][rt_addr], visible the next cycle.
  - An LSU write in the same cycle to the same register is not forwarded; rs/rt get the old value.
  - If load_issue is high and rd_addr is writable, set pending[warp_id][rd_addr].
- UPDATE (enable high), warp_id bank:
  - If reg_write_enable is high and rd_addr is writable:
    - ARITH: rd<=alu_out.
    - CONST: rd<=immediate.
    - MOVC: rd<=rs only if (nzp[warp_id] & decoded_nzp) != 0, using NZP as it was before this cycle.
    - MEMORY: no write; the data arrives via LSU.
  - If nzp_write_enable is high: nzp[warp_id]<=alu_out[2:0].
- LSU writeback (enable high, any state):
  - bank[lsu_wb_warp][lsu_wb_rd]<=lsu_wb_data and clear its pending bit.
  - Same cycle and same location as an UPDATE write: the LSU value is stored.
  - Same cycle as a pending set on the same entry: the set wins.
- hazard = enable & (pending[warp_id][rs_addr] | pending[warp_id][rt_addr] | pending[warp_id][rd_addr]). It is purely combinational, with no state gating.
- Other states: no register, NZP or rs/rt change except blk_load and LSU writeback.

Test Plan:
- Reset, then ISSUE with rs_addr=15, rt_addr=0, THREAD_ID=3 -> rs=3, rt=0; nzp=0; hazard=0.
- blk_load warp1, block_id=7, thread_count=4; ISSUE warp1 rs=13, rt=14 -> rs=7, rt=4; warp0 still reads 0, 0.
- Warp0 UPDATE CONST rd=2 imm=0x5A, then warp1 UPDATE CONST rd=2 imm=0x11 -> warp0 R2=0x5A, warp1 R2=0x11. A CONST write to rd=15 leaves 3.
- Warp0 ISSUE load_issue rd=4 -> hazard=1 when rs_addr=4 for warp0 and 0 for warp1. lsu_wb warp0 rd4 data 0x33 -> hazard=0, and a later ISSUE reads 0x33.
- CMP writes nzp=3'b010 on warp0; MOVC decoded_nzp=010, rs=0x21, rd=5 -> R5=0x21. MOVC with mask 100 leaves R5 unchanged.
- UPDATE ARITH rd=6 alu_out=0x10 concurrent with lsu_wb rd=6 data 0x99, same warp -> R6=0x99. Assert reset mid-pending -> hazard=0 and all pending bits cleared.
